// File: rtl/nec_bus_pkg.sv
// Shared bus-cycle types for the NEC-style bus target and bus controller.
package nec_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ADDR  = 2'd1,
        ST_REQ   = 2'd2,
        ST_READY = 2'd3
    } bus_state_e;

    // Everything about a bus cycle that has to outlive T1.
    typedef struct packed {
        logic [22:0] waddr;
        logic        r_w;
        logic [1:0]  be;
    } bus_cyc_t;

    localparam logic [3:0] WCNT_MAX = 4'hF;

    // Byte lanes: bit1 = upper byte (n_ube), bit0 = lower byte (even address).
    function automatic logic [1:0] byte_enables(input logic n_ube_i, input logic a0_i);
        return {~n_ube_i, ~a0_i};
    endfunction

endpackage

// File: rtl/bus_target_unit.sv
// Bus target: decodes a 24-bit bus window, forwards the cycle to a simple
// request/ack backend and answers the initiator with n_ready.
//
// state    | meaning
// ST_IDLE  | no cycle owned, decode on each T1 ce_2
// ST_ADDR  | cycle accepted, waiting for ce_1 to issue the backend request
// ST_REQ   | mem_req held high, waiting for mem_ack
// ST_READY | backend done; n_ready drops once wait states are met, ends on ce_2
module bus_target_unit
    import nec_bus_pkg::*;
#(
    parameter logic [23:0] BASE        = 24'h000000,
    parameter logic [23:0] MASK        = 24'hF00000,
    parameter logic        MEM_SPACE   = 1'b1,
    parameter logic [3:0]  WAIT_STATES = 4'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ce_1,
    input  logic        ce_2,
    input  logic        n_bcyst,
    input  logic        r_w,
    input  logic        m_io,
    input  logic        n_ube,
    input  logic [23:0] addr,
    input  logic [15:0] cpu_dout,
    output logic        n_ready,
    output logic        bs16,
    output logic        sel,
    output logic [15:0] rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [1:0]  mem_be,
    output logic [22:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata,
    output logic        protocol_fault
);

    bus_state_e  state_q, state_d;
    bus_cyc_t    cyc_q, cyc_d;
    logic [3:0]  wcnt_q, wcnt_d;
    logic        sel_q, sel_d;
    logic        n_ready_q, n_ready_d;
    logic [15:0] rdata_q, rdata_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [1:0]  mem_be_q, mem_be_d;
    logic [22:0] mem_addr_q, mem_addr_d;
    logic [15:0] mem_wdata_q, mem_wdata_d;
    logic        fault_q, fault_d;

    logic hit;
    logic t1_start;
    logic finishing;
    logic launch;

    // Window decode, evaluated every clk; only used when a T1 ce_2 is seen.
    always_comb begin
        hit = ((addr & MASK) == BASE) && (m_io == MEM_SPACE);
    end

    // Next-state and output logic for the cycle FSM.
    always_comb begin
        state_d     = state_q;
        cyc_d       = cyc_q;
        wcnt_d      = wcnt_q;
        sel_d       = sel_q;
        n_ready_d   = n_ready_q;
        rdata_d     = rdata_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_be_d    = mem_be_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        fault_d     = fault_q;

        t1_start  = ce_2 && !n_bcyst;
        // A completing ce_2 doubles as a legal T1 for the next cycle.
        finishing = (state_q == ST_READY) && ce_2 && !n_ready_q;
        launch    = t1_start && hit && ((state_q == ST_IDLE) || finishing);

        if (ce_2 && (state_q != ST_IDLE) && (wcnt_q != WCNT_MAX)) begin
            wcnt_d = wcnt_q + 4'd1;
        end

        if (t1_start && (state_q != ST_IDLE) && !finishing) begin
            fault_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                sel_d = 1'b0;
            end
            ST_ADDR: begin
                if (ce_1) begin
                    if (cyc_q.be == 2'b00) begin
                        rdata_d = 16'h0000;
                        state_d = ST_READY;
                    end else begin
                        if (!cyc_q.r_w) begin
                            mem_wdata_d = cpu_dout;
                        end
                        mem_req_d  = 1'b1;
                        mem_we_d   = ~cyc_q.r_w;
                        mem_be_d   = cyc_q.be;
                        mem_addr_d = cyc_q.waddr;
                        state_d    = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    if (cyc_q.r_w) begin
                        rdata_d = mem_rdata;
                    end
                    state_d = ST_READY;
                end
            end
            ST_READY: begin
                // Counter never decreases, so once met n_ready stays low.
                if (wcnt_q >= WAIT_STATES) begin
                    n_ready_d = 1'b0;
                end
                if (finishing) begin
                    sel_d     = 1'b0;
                    n_ready_d = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (launch) begin
            cyc_d     = '{waddr: addr[23:1], r_w: r_w, be: byte_enables(n_ube, addr[0])};
            wcnt_d    = 4'd0;
            sel_d     = 1'b1;
            n_ready_d = 1'b1;
            state_d   = ST_ADDR;
        end
    end

    // Register every flop; synchronous reset puts the target back to idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cyc_q       <= '0;
            wcnt_q      <= 4'd0;
            sel_q       <= 1'b0;
            n_ready_q   <= 1'b1;
            rdata_q     <= 16'h0000;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= 2'b00;
            mem_addr_q  <= 23'h0;
            mem_wdata_q <= 16'h0000;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cyc_q       <= cyc_d;
            wcnt_q      <= wcnt_d;
            sel_q       <= sel_d;
            n_ready_q   <= n_ready_d;
            rdata_q     <= rdata_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_be_q    <= mem_be_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            fault_q     <= fault_d;
        end
    end

    assign sel            = sel_q;
    assign bs16           = sel_q;
    assign n_ready        = n_ready_q;
    assign rdata          = rdata_q;
    assign mem_req        = mem_req_q;
    assign mem_we         = mem_we_q;
    assign mem_be         = mem_be_q;
    assign mem_addr       = mem_addr_q;
    assign mem_wdata      = mem_wdata_q;
    assign protocol_fault = fault_q;

endmodule

// File: doc/bus_target_unit.md
BUS_TARGET_UNIT -- requirements
Module: bus_target_unit

Interface
REQ-001 SHALL have parameters: BASE (24-bit, 24'h000000, window base); MASK (24-bit, 24'hF00000, window decode mask); MEM_SPACE (1-bit, 1, m_io value served); WAIT_STATES (4-bit, 0, minimum wait states inserted).
REQ-002 SHALL have ports, clock and reset first:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- ce_1, ce_2  in  1 each  phase clock enables
- n_bcyst  in  1  bus cycle start, low during T1
- r_w  in  1  1=read, 0=write
- m_io  in  1  1=memory, 0=I/O
- n_ube  in  1  upper byte enable, active low
- addr  in  24  bus address
- cpu_dout  in  16  write data from initiator
- n_ready  out  1  ready to initiator, active low
- bs16  out  1  16-bit bus width indication
- sel  out  1  target owns current cycle; n_ready/bs16/rdata valid only when high
- rdata  out  16  read data to initiator
- mem_req  out  1  backend request, level
- mem_we  out  1  backend write strobe qualifier
- mem_be  out  2  backend byte enables, bit1=upper
- mem_addr  out  23  backend word address
- mem_wdata  out  16  backend write data
- mem_ack  in  1  backend completion, one-clk pulse
- mem_rdata  in  16  backend read data, valid with mem_ack
- protocol_fault  out  1  sticky protocol violation flag

Function
REQ-003 SHALL implement states IDLE, ADDR, REQ, READY; all transitions only on ce_1/ce_2 except REQ->READY on mem_ack.
REQ-004 SHALL decode hit = ((addr & MASK) == BASE) && (m_io == MEM_SPACE), sampled at ce_2 with n_bcyst low.
REQ-005 IDLE: on ce_2 with n_bcyst low and hit SHALL latch addr[23:1], r_w, be = {~n_ube, ~addr[0]}, clear wait counter, set sel=1, n_ready=1, go ADDR; miss SHALL stay IDLE with sel=0.
REQ-006 ADDR: on next ce_1 SHALL latch cpu_dout into mem_wdata (writes only), assert mem_req, drive mem_we=~r_w, mem_be, mem_addr, go REQ.
REQ-007 ADDR with be==2'b00 SHALL skip the backend (no mem_req) and go READY with rdata=16'h0000.
REQ-008 REQ: mem_req SHALL stay high until the clk on which mem_ack is sampled high, deasserting on the following clk; read data SHALL be captured into rdata on that clk.
REQ-009 wait counter SHALL increment (saturating at 15) on every ce_2 while in ADDR/REQ/READY.
REQ-010 n_ready SHALL go low the clk after both ack received and counter >= WAIT_STATES, held low until cycle end.
REQ-011 READY: on ce_2 with n_ready low SHALL complete the cycle: sel=0, n_ready=1, go IDLE; rdata held until then.
REQ-012 bs16 SHALL be 1 whenever sel=1, 0 otherwise.
REQ-013 n_bcyst low at ce_2 while not IDLE SHALL set protocol_fault and be otherwise ignored.
REQ-014 mem_ack outside REQ SHALL be ignored and SHALL NOT change any output.
REQ-015 Same-clk ce_2 completion and n_bcyst low SHALL complete current cycle, then decode the new cycle in that same ce_2 (back-to-back, no idle gap).

Reset
REQ-016 reset SHALL force state IDLE, sel=0, n_ready=1, bs16=0, mem_req=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0, rdata=0, protocol_fault=0, counter=0.
REQ-017 reset mid-cycle SHALL drop mem_req on the next clk; a later stale mem_ack SHALL be ignored.

Structure
REQ-018 State enum and bus-cycle capture struct (word addr, r_w, be) SHALL live in shared package nec_bus_pkg, also used by bus_control_unit.
REQ-019 No sub-module; single always_ff plus combinational hit decode; target 150-300 lines.

Verification
REQ-020 Read, WAIT_STATES=0, addr=24'h000124, n_ube=0, ack 1 clk after req with 16'hBEEF -> mem_addr=23'h000092, mem_be=11, n_ready low before T2 ce_2, rdata=16'hBEEF, no T_WAIT.
REQ-021 Write, WAIT_STATES=3, addr=24'h000011, n_ube=0, cpu_dout=16'h5A00 -> mem_be=10, mem_we=1, mem_wdata=16'h5A00, n_ready low only after 3rd ce_2.
REQ-022 Miss, addr=24'h100000 or m_io=0 -> sel=0, mem_req never asserted.
REQ-023 Backend ack delayed 20 clks -> n_ready stays 1 throughout, mem_req held, completes after ack.
REQ-024 Reset asserted in REQ, then mem_ack pulse -> all outputs at reset values, state IDLE, rdata stays 0.
REQ-025 n_bcyst low during REQ -> protocol_fault=1 and remains 1 until reset.
